// File: rtl/mm_regfile_qos.sv
// Purpose: memory-mapped control/status registers, error counters and interrupts for QoS channel selection.
// Latency: read data, read-valid and access error appear one cycle after the strobe; writes reach outputs next cycle.
// Backpressure: none; every strobe is accepted, so strobes held high are independent back-to-back accesses.
module mm_regfile_qos #(
    parameter int  NUM_CH = 4,
    parameter int  CNT_W  = 16,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                mm_write_en,
    input  logic                mm_read_en,
    input  logic [7:0]          mm_addr,
    input  logic [31:0]         mm_wdata,
    output logic [31:0]         mm_rdata,
    output logic                mm_rvalid,
    output logic                mm_err,
    output logic                irq,
    output logic                fallback_enable,
    output logic                manual_enable,
    output logic [CH_W-1:0]     manual_channel,
    output logic [19:0]         reset_timer,
    output logic [2*NUM_CH-1:0] channel_priority,
    input  logic [CH_W-1:0]     active_channel,
    input  logic [NUM_CH-1:0]   signal_present,
    input  logic [NUM_CH-1:0]   err_pulse
);

    localparam logic [7:0]       ADDR_CTRL   = 8'h00;
    localparam logic [7:0]       ADDR_PRIO   = 8'h01;
    localparam logic [7:0]       ADDR_STATUS = 8'h02;
    localparam logic [7:0]       ADDR_ISTAT  = 8'h03;
    localparam logic [7:0]       ADDR_IMASK  = 8'h04;
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    // Control register image; only the implemented fields are stored.
    typedef struct packed {
        logic [19:0]     reset_timer;
        logic [CH_W-1:0] manual_channel;
        logic            manual_enable;
        logic            fallback_enable;
    } ctrl_t;

    // Interrupt status/mask layout: one loss bit per channel plus the channel-change bit.
    typedef struct packed {
        logic              chg;
        logic [NUM_CH-1:0] loss;
    } irq_t;

    ctrl_t               ctrl_q;
    ctrl_t               ctrl_wr;
    logic [2*NUM_CH-1:0] prio_q;
    irq_t                irq_stat_q;
    irq_t                irq_mask_q;
    irq_t                irq_wr;
    irq_t                irq_w1c;
    irq_t                irq_set;
    logic [CNT_W-1:0]    cnt_q [NUM_CH];
    logic [NUM_CH-1:0]   cnt_clr;
    logic [NUM_CH-1:0]   sig_prev_q;
    logic [CH_W-1:0]     ach_prev_q;

    logic                is_ctrl;
    logic                is_prio;
    logic                is_status;
    logic                is_istat;
    logic                is_imask;
    logic                is_cnt;
    logic [2:0]          cnt_idx;
    logic                ctrl_bad;
    logic                rd_hit;
    logic                wr_ok;
    logic                rd_err;
    logic                wr_err;
    logic [31:0]         rd_data;
    logic                unused_wdata;

    // Bits 11:5 of write data only matter for some parameterisations (wide PRIO, mask bit 8).
    assign unused_wdata = ^mm_wdata[11:5];

    assign is_ctrl   = (mm_addr == ADDR_CTRL);
    assign is_prio   = (mm_addr == ADDR_PRIO);
    assign is_status = (mm_addr == ADDR_STATUS);
    assign is_istat  = (mm_addr == ADDR_ISTAT);
    assign is_imask  = (mm_addr == ADDR_IMASK);
    assign cnt_idx   = mm_addr[2:0];
    assign is_cnt    = (mm_addr[7:3] == 5'b00010) && (int'(cnt_idx) < NUM_CH);

    // A manual channel index outside the channel range rejects the whole CTRL write.
    assign ctrl_bad  = (int'(mm_wdata[4:2]) >= NUM_CH);

    assign rd_hit    = is_ctrl | is_prio | is_status | is_istat | is_imask | is_cnt;
    assign wr_ok     = (is_ctrl & ~ctrl_bad) | is_prio | is_istat | is_imask;
    assign rd_err    = mm_read_en & ~rd_hit;
    assign wr_err    = mm_write_en & ~wr_ok;

    // Unpack write data into the CTRL and interrupt register layouts.
    always_comb begin
        ctrl_wr                 = '0;
        ctrl_wr.fallback_enable = mm_wdata[0];
        ctrl_wr.manual_enable   = mm_wdata[1];
        ctrl_wr.manual_channel  = mm_wdata[2 +: CH_W];
        ctrl_wr.reset_timer     = mm_wdata[31:12];
        irq_wr                  = '0;
        irq_wr.loss             = mm_wdata[NUM_CH-1:0];
        irq_wr.chg              = mm_wdata[8];
    end

    // Read mux over current register values, so a same-cycle write is not yet visible.
    always_comb begin
        rd_data = '0;
        if (is_ctrl) begin
            rd_data[0]           = ctrl_q.fallback_enable;
            rd_data[1]           = ctrl_q.manual_enable;
            rd_data[2 +: CH_W]   = ctrl_q.manual_channel;
            rd_data[31:12]       = ctrl_q.reset_timer;
        end else if (is_prio) begin
            rd_data[2*NUM_CH-1:0] = prio_q;
        end else if (is_status) begin
            rd_data[CH_W-1:0]    = active_channel;
            rd_data[8 +: NUM_CH] = signal_present;
        end else if (is_istat) begin
            rd_data[NUM_CH-1:0]  = irq_stat_q.loss;
            rd_data[8]           = irq_stat_q.chg;
        end else if (is_imask) begin
            rd_data[NUM_CH-1:0]  = irq_mask_q.loss;
            rd_data[8]           = irq_mask_q.chg;
        end else if (is_cnt) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (int'(cnt_idx) == k) begin
                    rd_data[CNT_W-1:0] = cnt_q[k];
                end
            end
        end
    end

    // Host writes to the RW registers; rejected or misdirected writes leave them untouched.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ctrl_q     <= '0;
            prio_q     <= '0;
            irq_mask_q <= '0;
        end else if (mm_write_en) begin
            if (is_ctrl && !ctrl_bad) begin
                ctrl_q <= ctrl_wr;
            end
            if (is_prio) begin
                prio_q <= mm_wdata[2*NUM_CH-1:0];
            end
            if (is_imask) begin
                irq_mask_q <= irq_wr;
            end
        end
    end

    // Per-channel clear strobes for reads of the error counters.
    always_comb begin
        cnt_clr = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cnt_clr[k] = mm_read_en && is_cnt && (int'(cnt_idx) == k);
        end
    end

    // Saturating error counters; a pulse coinciding with the clearing read restarts the count at 1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NUM_CH; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (cnt_clr[k]) begin
                    cnt_q[k] <= err_pulse[k] ? CNT_ONE : '0;
                end else if (err_pulse[k] && (cnt_q[k] != CNT_MAX)) begin
                    cnt_q[k] <= cnt_q[k] + CNT_ONE;
                end
            end
        end
    end

    // Interrupt event detection against last cycle's inputs, plus W1C strobes.
    always_comb begin
        irq_set      = '0;
        irq_set.loss = sig_prev_q & ~signal_present;
        irq_set.chg  = (active_channel != ach_prev_q);
        irq_w1c      = '0;
        if (mm_write_en && is_istat) begin
            irq_w1c = irq_wr;
        end
    end

    // Sticky status bits (set beats clear), input history, and the registered interrupt line.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            irq_stat_q <= '0;
            sig_prev_q <= '0;
            ach_prev_q <= '0;
            irq        <= 1'b0;
        end else begin
            irq_stat_q <= (irq_stat_q & ~irq_w1c) | irq_set;
            sig_prev_q <= signal_present;
            ach_prev_q <= active_channel;
            irq        <= |(irq_stat_q & irq_mask_q);
        end
    end

    // Bus response: read data holds between reads, valid and error are single-cycle pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mm_rdata  <= '0;
            mm_rvalid <= 1'b0;
            mm_err    <= 1'b0;
        end else begin
            if (mm_read_en) begin
                mm_rdata <= rd_data;
            end
            mm_rvalid <= mm_read_en;
            mm_err    <= rd_err | wr_err;
        end
    end

    assign fallback_enable  = ctrl_q.fallback_enable;
    assign manual_enable    = ctrl_q.manual_enable;
    assign manual_channel   = ctrl_q.manual_channel;
    assign reset_timer      = ctrl_q.reset_timer;
    assign channel_priority = prio_q;

endmodule

// File: doc/mm_regfile_qos.md
Name: mm_regfile_qos

Overview:
- Parametrised memory-mapped control/status register file for the QoS channel-selection datapath; generalises the fixed 4-channel, 3-register map to NUM_CH channels.
- Adds a read-valid handshake, address-error reporting, saturating clear-on-read per-channel error counters, and sticky maskable interrupts for signal loss and active-channel change.
- Sits between the host bus and main_control.

Parameters:
- NUM_CH, 4, number of input channels, legal range 2..8
- CNT_W, 16, width of each internal error counter, legal range 1..32
- CH_W, $clog2(NUM_CH), width of channel index outputs (derived, not overridable)

Ports:
- clk  in  1  clock
- rstn  in  1  reset
- mm_write_en  in  1  write strobe, single cycle
- mm_read_en  in  1  read strobe, single cycle
- mm_addr  in  8  word address
- mm_wdata  in  32  write data
- mm_rdata  out  32  read data, registered
- mm_rvalid  out  1  read-data valid pulse
- mm_err  out  1  access-error pulse
- irq  out  1  level interrupt, registered
- fallback_enable  out  1  CTRL[0]
- manual_enable  out  1  CTRL[1]
- manual_channel  out  CH_W  CTRL[4:2], low CH_W bits
- reset_timer  out  20  CTRL[31:12]
- channel_priority  out  2*NUM_CH  PRIO[2*NUM_CH-1:0]
- active_channel  in  CH_W  from main_control
- signal_present  in  NUM_CH  from main_control, synchronous to clk
- err_pulse  in  NUM_CH  one-cycle error event per channel

Behaviour:
- Reset rstn, asynchronous, active-low; clock clk. All registers, counters, mm_rdata, mm_rvalid, mm_err and irq reset to 0. The signal_present history register resets to 0, so no loss event can occur at reset exit.
- Register map, all addresses word-sized; unused bits read 0 and ignore writes:
  - 0x00 CTRL (RW): [0] fallback, [1] manual_en, [4:2] manual_channel, [31:12] reset_timer.
  - 0x01 PRIO (RW): [2*NUM_CH-1:0].
  - 0x02 STATUS (RO): [2:0] active_channel, [15:8] signal_present, both zero-extended.
  - 0x03 IRQ_STAT (W1C): [NUM_CH-1:0] signal-loss per channel, [8] active-channel change.
  - 0x04 IRQ_MASK (RW): same layout as IRQ_STAT.
  - 0x10+k ERRCNT_k (RO, clear-on-read), k = 0..NUM_CH-1: counter zero-extended to 32 bits.
- Read latency:
  - mm_read_en at cycle N gives mm_rdata and mm_rvalid=1 at N+1. mm_rvalid is a single-cycle pulse.
  - mm_rdata holds its last value when no read is in progress.
  - STATUS returns inputs sampled at cycle N.
- Unmapped address:
  - Read returns 0 with mm_rvalid=1 and mm_err=1 at N+1.
  - Write to an unmapped or RO address (0x02, 0x10+) is ignored; mm_err=1 at N+1.
- CTRL write with mm_wdata[4:2] >= NUM_CH is rejected entirely: CTRL is unchanged and mm_err=1 at N+1.
- Simultaneous read and write in the same cycle:
  - Both are performed.
  - The read returns the pre-write value.
  - mm_err is the OR of both error conditions.
- Write effects appear on the outputs at N+1.
- Error counters:
  - Each err_pulse[k] increments cnt_k by 1; the counter saturates at 2^CNT_W-1 with no wrap.
  - A read of ERRCNT_k returns the current value, then clears the counter.
  - If err_pulse[k] coincides with the clearing read, cnt_k becomes 1, so no event is lost.
- Interrupt sources:
  - IRQ_STAT[k] sets on a falling edge of signal_present[k], detected against a one-cycle-delayed copy.
  - IRQ_STAT[8] sets when active_channel differs from its value on the previous cycle.
  - Bits are sticky and cleared by writing 1 to them; when set and W1C coincide, set wins.
- irq = |(IRQ_STAT & IRQ_MASK), registered, so it asserts one cycle after the status bit is set or the mask bit is enabled.
- mm_write_en and mm_read_en held high across several cycles are treated as independent back-to-back accesses.

Test Plan:
- Reset, then read 0x00..0x04 -> each returns 0 with mm_rvalid one cycle after mm_read_en; mm_err=0.
- NUM_CH=4: write 0x00 = 0xABCDE00D -> fallback=1, manual_enable=0, manual_channel=3, reset_timer=0xABCDE; readback 0x00 = 0xABCDE00D & 0xFFFFF01F. Then write 0x00 = 0x00000011 (manual_channel=4) -> mm_err=1, CTRL unchanged.
- CNT_W=4: pulse err_pulse[2] 20 times -> ERRCNT_2 reads 15. Immediate re-read -> 0. Read coinciding with a pulse -> returns the count; next read returns 1.
- IRQ_MASK = 0x001, drop signal_present[0] 1->0 -> IRQ_STAT reads 0x001 and irq=1. Write 0x001 to 0x03 -> irq=0. Repeat with W1C coinciding with a new falling edge -> bit stays 1.
- Change active_channel 1->2 with mask 0x100 -> IRQ_STAT[8]=1 and irq=1. Read 0x05 -> rdata=0, mm_err=1. Write 0x02 -> ignored, mm_err=1.
- Assert rstn low mid-count with irq set -> all outputs 0 immediately; no spurious irq after rstn release even with signal_present low.
